// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// State encodings are plain 2-bit constants so legacy code can use the same values.
package ram_arb_pkg;

    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DATA_W = 8;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t ACCESS = 2'd1;
    localparam state_t RDWAIT = 2'd2;
    localparam state_t DONE   = 2'd3;

    typedef logic port_id_t;

    localparam port_id_t P0 = 1'b0;
    localparam port_id_t P1 = 1'b1;

    // Round-robin pick: a lone requester wins outright; under contention the
    // port that was not served last goes next.
    function automatic port_id_t rr_pick(
        input logic     req0,
        input logic     req1,
        input port_id_t last_grant
    );
        port_id_t pick;
        if (req0 && req1) begin
            pick = (last_grant == P0) ? P1 : P0;
        end else if (req1) begin
            pick = P1;
        end else begin
            pick = P0;
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker.
// gnt_id is only meaningful while gnt_valid is high.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic     req0,
    input  logic     req1,
    input  port_id_t last_grant,
    output logic     gnt_valid,
    output port_id_t gnt_id
);

    always_comb begin
        gnt_valid = req0 | req1;
        gnt_id    = rr_pick(req0, req1, last_grant);
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin sequencer sharing one single-port synchronous RAM between two
// req/ack requesters. All outputs are registered except the ram_data driver.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,

    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,

    output logic              ram_cs,
    output logic              ram_wr_e,
    output logic              ram_oe,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data,

    output logic              busy
);

    // Per-port views so the per-port logic can be generated.
    logic              we_vec    [2];
    logic [ADDR_W-1:0] addr_vec  [2];
    logic [DATA_W-1:0] wdata_vec [2];
    logic              ack_vec   [2];
    logic [DATA_W-1:0] rdata_vec [2];

    assign we_vec[0]    = we0;
    assign we_vec[1]    = we1;
    assign addr_vec[0]  = addr0;
    assign addr_vec[1]  = addr1;
    assign wdata_vec[0] = wdata0;
    assign wdata_vec[1] = wdata1;

    state_t            state_reg;
    state_t            state_next;
    port_id_t          last_grant_reg;

    port_id_t          cmd_id_reg;
    logic              cmd_we_reg;
    logic [ADDR_W-1:0] cmd_addr_reg;
    logic [DATA_W-1:0] cmd_wdata_reg;

    logic              ram_cs_reg;
    logic              ram_wr_e_reg;
    logic              ram_oe_reg;
    logic [ADDR_W-1:0] ram_addr_reg;
    logic              busy_reg;

    logic              gnt_valid;
    port_id_t          gnt_id;
    logic              grant_now;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;

    rr_arb2 u_rr_arb2 (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant_reg),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    assign grant_now = (state_reg == IDLE) && gnt_valid;

    // The RAM controls for ACCESS are registered on the same edge that loads
    // the command register, so on a grant they come straight from the winner.
    always_comb begin
        sel_we   = cmd_we_reg;
        sel_addr = cmd_addr_reg;
        if (grant_now) begin
            sel_we   = we_vec[gnt_id];
            sel_addr = addr_vec[gnt_id];
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (gnt_valid) state_next = ACCESS;
            ACCESS:  state_next = cmd_we_reg ? DONE : RDWAIT;
            RDWAIT:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= P1;
            busy_reg       <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next != IDLE);
            if (state_next == DONE) begin
                last_grant_reg <= cmd_id_reg;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_id_reg    <= P0;
            cmd_we_reg    <= 1'b0;
            cmd_addr_reg  <= '0;
            cmd_wdata_reg <= '0;
        end else if (grant_now) begin
            cmd_id_reg    <= gnt_id;
            cmd_we_reg    <= we_vec[gnt_id];
            cmd_addr_reg  <= addr_vec[gnt_id];
            cmd_wdata_reg <= wdata_vec[gnt_id];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_cs_reg   <= 1'b0;
            ram_wr_e_reg <= 1'b0;
            ram_oe_reg   <= 1'b0;
            ram_addr_reg <= '0;
        end else begin
            ram_cs_reg   <= (state_next == ACCESS) || (state_next == RDWAIT);
            ram_wr_e_reg <= (state_next == ACCESS) && sel_we;
            ram_oe_reg   <= ((state_next == ACCESS) && !sel_we) || (state_next == RDWAIT);
            if (state_next == ACCESS) begin
                ram_addr_reg <= sel_addr;
            end
        end
    end

    // Each port owns its ack pulse and read-data holding register; only the
    // granted port's registers ever move.
    for (genvar gi = 0; gi < 2; gi++) begin : gen_port
        logic              ack_r;
        logic [DATA_W-1:0] rdata_r;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ack_r   <= 1'b0;
                rdata_r <= '0;
            end else begin
                ack_r <= (state_next == DONE) && (cmd_id_reg == port_id_t'(gi));
                if ((state_reg == RDWAIT) && (cmd_id_reg == port_id_t'(gi))) begin
                    rdata_r <= ram_data;
                end
            end
        end

        assign ack_vec[gi]   = ack_r;
        assign rdata_vec[gi] = rdata_r;
    end

    // The bus is driven only during a write ACCESS cycle; the RAM drives it
    // during reads, so the two drivers never overlap.
    assign ram_data = ram_wr_e_reg ? cmd_wdata_reg : {DATA_W{1'bz}};

    assign ack0     = ack_vec[0];
    assign ack1     = ack_vec[1];
    assign rdata0   = rdata_vec[0];
    assign rdata1   = rdata_vec[1];
    assign ram_cs   = ram_cs_reg;
    assign ram_wr_e = ram_wr_e_reg;
    assign ram_oe   = ram_oe_reg;
    assign ram_addr = ram_addr_reg;
    assign busy     = busy_reg;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 128x8 registered-read RAM.
module tb_ram_arbiter;

    logic       clk;
    logic       rst;
    logic       req0, we0, req1, we1;
    logic [6:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       ack0, ack1;
    logic [7:0] rdata0, rdata1;
    logic       ram_cs, ram_wr_e, ram_oe;
    logic [6:0] ram_addr;
    wire  [7:0] ram_data;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    ram_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .we0      (we0),
        .addr0    (addr0),
        .wdata0   (wdata0),
        .ack0     (ack0),
        .rdata0   (rdata0),
        .req1     (req1),
        .we1      (we1),
        .addr1    (addr1),
        .wdata1   (wdata1),
        .ack1     (ack1),
        .rdata1   (rdata1),
        .ram_cs   (ram_cs),
        .ram_wr_e (ram_wr_e),
        .ram_oe   (ram_oe),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .busy     (busy)
    );

    // Behavioural single-port RAM with a registered read.
    logic [7:0] mem [128];
    logic [7:0] ram_q;

    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_wr_e) mem[ram_addr] <= ram_data;
            else if (ram_oe) ram_q <= mem[ram_addr];
        end
    end

    assign ram_data = (ram_cs && ram_oe && !ram_wr_e) ? ram_q : 8'hzz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int         n0, n1;
    int         ack0_t [4];
    int         ack1_t [4];
    logic [7:0] rd1_at [4];
    logic [7:0] rd0_at;
    logic [8:1] exp_busy, exp_ack0, exp_ack1;

    initial begin
        rst = 1'b1;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        ram_q = 8'h00;

        // Reset state
        tick(); tick();
        chk("rst_ack0", ack0, 0);
        chk("rst_ack1", ack1, 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_rdata1", rdata1, 0);
        chk("rst_cs", ram_cs, 0);
        chk("rst_wr_e", ram_wr_e, 0);
        chk("rst_oe", ram_oe, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        tick();
        $display("txn: reset released");

        // Port 0 write addr 5 <- 45
        req0 = 1; we0 = 1; addr0 = 7'd5; wdata0 = 8'h45;
        tick();
        chk("w0_acc_cs", ram_cs, 1);
        chk("w0_acc_wr_e", ram_wr_e, 1);
        chk("w0_acc_oe", ram_oe, 0);
        chk("w0_acc_addr", ram_addr, 5);
        chk("w0_acc_data", ram_data, 8'h45);
        chk("w0_acc_busy", busy, 1);
        chk("w0_acc_ack0", ack0, 0);
        tick();
        chk("w0_done_ack0", ack0, 1);
        chk("w0_done_wr_e", ram_wr_e, 0);
        chk("w0_done_cs", ram_cs, 0);
        req0 = 0;
        tick();
        chk("w0_idle_ack0", ack0, 0);
        chk("w0_idle_busy", busy, 0);
        chk("w0_mem5", mem[5], 8'h45);
        $display("txn: p0 write addr=5 data=45");

        // Port 0 read addr 5
        req0 = 1; we0 = 0; addr0 = 7'd5;
        tick();
        chk("r0_acc_cs", ram_cs, 1);
        chk("r0_acc_oe", ram_oe, 1);
        chk("r0_acc_wr_e", ram_wr_e, 0);
        tick();
        chk("r0_rdw_oe", ram_oe, 1);
        chk("r0_rdw_ack0", ack0, 0);
        tick();
        chk("r0_done_ack0", ack0, 1);
        chk("r0_done_rdata0", rdata0, 8'h45);
        chk("r0_done_cs", ram_cs, 0);
        req0 = 0;
        tick();
        chk("r0_idle_ack0", ack0, 0);
        $display("txn: p0 read addr=5 rdata0=%0h", rdata0);

        // Reset pulse restores last_grant so port 0 wins the next contention
        rst = 1;
        tick();
        rst = 0;
        tick();

        // Contention writes
        req0 = 1; we0 = 1; addr0 = 7'd14;  wdata0 = 8'h37;
        req1 = 1; we1 = 1; addr1 = 7'd127; wdata1 = 8'hA5;
        tick();
        chk("cw_p0_addr", ram_addr, 14);
        chk("cw_p0_data", ram_data, 8'h37);
        tick();
        chk("cw_p0_ack0", ack0, 1);
        chk("cw_p0_ack1", ack1, 0);
        req0 = 0;
        tick();
        chk("cw_gap_busy", busy, 0);
        tick();
        chk("cw_p1_addr", ram_addr, 127);
        chk("cw_p1_data", ram_data, 8'hA5);
        tick();
        chk("cw_p1_ack1", ack1, 1);
        chk("cw_p1_ack0", ack0, 0);
        $display("txn: contention writes p0 addr=14 p1 addr=127");

        // Contention reads, port 0 first again
        req0 = 1; we0 = 0; addr0 = 7'd14;
        req1 = 1; we1 = 0; addr1 = 7'd127;
        tick();
        tick();
        chk("cr_p0_addr", ram_addr, 14);
        tick();
        chk("cr_p0_rdw_rdata1", rdata1, 0);
        tick();
        chk("cr_p0_ack0", ack0, 1);
        chk("cr_p0_ack1", ack1, 0);
        chk("cr_rdata0", rdata0, 8'h37);
        chk("cr_rdata1_unch", rdata1, 0);
        req0 = 0;
        tick();
        tick();
        chk("cr_p1_addr", ram_addr, 127);
        tick();
        tick();
        chk("cr_p1_ack1", ack1, 1);
        chk("cr_rdata1", rdata1, 8'hA5);
        chk("cr_rdata0_unch", rdata0, 8'h37);
        req1 = 0;
        tick();
        $display("txn: contention reads rdata0=%0h rdata1=%0h", rdata0, rdata1);

        // Port 1 holds req for three reads; port 0 cuts in after the first
        n0 = 0; n1 = 0;
        req1 = 1; we1 = 0; addr1 = 7'd127;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (t == 2) begin
                req0 = 1; we0 = 0; addr0 = 7'd14;
            end
            if (ack0) begin
                if (n0 < 4) ack0_t[n0] = t;
                rd0_at = rdata0;
                n0++;
                req0 = 0;
            end
            if (ack1) begin
                if (n1 < 4) begin
                    ack1_t[n1] = t;
                    rd1_at[n1] = rdata1;
                end
                n1++;
                if (n1 == 3) req1 = 0;
            end
        end
        chk("hold_n0", n0, 1);
        chk("hold_n1", n1, 3);
        chk("hold_ack1_a", ack1_t[0], 3);
        chk("hold_ack0", ack0_t[0], 7);
        chk("hold_ack1_b", ack1_t[1], 11);
        chk("hold_ack1_c", ack1_t[2], 15);
        chk("hold_rd0", rd0_at, 8'h37);
        chk("hold_rd1_a", rd1_at[0], 8'hA5);
        chk("hold_rd1_c", rd1_at[2], 8'hA5);
        $display("txn: p1 held 3 reads, p0 interleaved at t=%0d", ack0_t[0]);

        // Port 0 write raised while port 1 read is in flight
        exp_busy = 8'b0011_0111;
        exp_ack0 = 8'b0010_0000;
        exp_ack1 = 8'b0000_0100;
        req1 = 1; we1 = 0; addr1 = 7'd127;
        for (int t = 1; t <= 8; t++) begin
            tick();
            if (t == 1) begin
                req0 = 1; we0 = 1; addr0 = 7'd20; wdata0 = 8'h5A;
            end
            chk($sformatf("busy_t%0d", t), busy, exp_busy[t]);
            chk($sformatf("ack0_t%0d", t), ack0, exp_ack0[t]);
            chk($sformatf("ack1_t%0d", t), ack1, exp_ack1[t]);
            if (ack0) req0 = 0;
            if (ack1) req1 = 0;
        end
        chk("busyw_mem20", mem[20], 8'h5A);
        $display("txn: p0 write queued behind p1 read");

        // Asynchronous reset during RDWAIT
        req0 = 1; we0 = 0; addr0 = 7'd14;
        tick();
        tick();
        chk("ar_rdw_oe", ram_oe, 1);
        chk("ar_rdw_busy", busy, 1);
        #3;
        rst = 1;
        #1;
        chk("ar_cs", ram_cs, 0);
        chk("ar_oe", ram_oe, 0);
        chk("ar_busy", busy, 0);
        chk("ar_ack0", ack0, 0);
        chk("ar_rdata0", rdata0, 0);
        tick();
        req0 = 0;
        tick();
        rst = 0;
        for (int t = 0; t < 3; t++) begin
            tick();
            chk("ar_noack0", ack0, 0);
        end
        $display("txn: reset during read");

        // First contention after reset goes to port 0
        req0 = 1; we0 = 1; addr0 = 7'd9;  wdata0 = 8'h11;
        req1 = 1; we1 = 1; addr1 = 7'd10; wdata1 = 8'h22;
        tick();
        chk("pr_p0_addr", ram_addr, 9);
        tick();
        chk("pr_ack0", ack0, 1);
        chk("pr_ack1", ack1, 0);
        req0 = 0;
        tick();
        tick();
        chk("pr_p1_addr", ram_addr, 10);
        tick();
        chk("pr_ack1b", ack1, 1);
        req1 = 0;
        tick();
        chk("pr_mem9", mem[9], 8'h11);
        chk("pr_mem10", mem[10], 8'h22);
        $display("txn: post-reset contention p0 then p1");

        // Idle
        for (int t = 0; t < 10; t++) begin
            tick();
            chk("idle_cs", ram_cs, 0);
            chk("idle_wr_e", ram_wr_e, 0);
            chk("idle_busy", busy, 0);
        end
        $display("txn: idle 10 cycles");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
